parking_slot_allocator: RTL



---
 rtl/parking_slot_allocator.sv | 133 +++++++++++++
 1 files changed

// File: rtl/parking_slot_allocator.sv
// parking_slot_allocator: two-gate round-robin slot allocator with EV-charger reservation and occupancy tracking.
module parking_slot_allocator #(
    parameter int                   NUM_SLOTS    = 16,
    parameter int                   SLOT_W       = 4,
    parameter logic [NUM_SLOTS-1:0] CHARGER_MASK = 16'hF000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 g0_req,
    input  logic                 g0_charge,
    input  logic                 g1_req,
    input  logic                 g1_charge,
    input  logic                 exit_valid,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 g0_grant,
    output logic                 g1_grant,
    output logic                 deny,
    output logic [1:0]           deny_code,
    output logic                 resp_gate,
    output logic [SLOT_W-1:0]    grant_slot,
    output logic                 exit_err,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [SLOT_W:0]      free_count,
    output logic                 lot_full
);
    typedef enum logic [1:0] {IDLE, SEARCH, RESP, WAIT_DROP} state_t;
    state_t state, state_next;
    logic sel_gate, sel_charge, rr_last, pick, served_req;
    logic cand_ok, s_ok, granting, refusing, exit_hit;
    logic [SLOT_W-1:0] cand_slot, s_slot, ch_idx, nc_idx;
    logic [1:0] cand_code, s_code;
    logic ch_found, nc_found;
    logic [NUM_SLOTS-1:0] free_slots, ch_free, nc_free, exit_mask, grant_mask, occ_next;
    logic [SLOT_W:0] free_next;

    assign pick       = (g0_req && g1_req) ? ~rr_last : g1_req;
    assign served_req = sel_gate ? g1_req : g0_req;
    assign free_slots = ~occupied;
    assign ch_free    = free_slots & CHARGER_MASK;
    assign nc_free    = free_slots & ~CHARGER_MASK;

    // Descending scan so the lowest free index is the one left standing.
    always_comb begin
        ch_found = 1'b0;
        ch_idx   = '0;
        nc_found = 1'b0;
        nc_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (ch_free[i]) begin
                ch_found = 1'b1;
                ch_idx   = SLOT_W'(i);
            end
            if (nc_free[i]) begin
                nc_found = 1'b1;
                nc_idx   = SLOT_W'(i);
            end
        end
    end

    assign s_ok   = sel_charge ? ch_found : (nc_found || ch_found);
    assign s_slot = (sel_charge || !nc_found) ? ch_idx : nc_idx;
    assign s_code = (free_slots == '0) ? 2'b01 : 2'b10;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      state_next = (g0_req || g1_req) ? SEARCH : IDLE;
            SEARCH:    state_next = RESP;
            RESP:      state_next = WAIT_DROP;
            WAIT_DROP: state_next = served_req ? WAIT_DROP : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A grant and an exit on the same slot: exit is judged on the old map, grant wins.
    assign granting   = (state == RESP) && cand_ok;
    assign refusing   = (state == RESP) && !cand_ok;
    assign exit_hit   = exit_valid && occupied[exit_slot];
    assign exit_mask  = exit_hit ? (NUM_SLOTS'(1) << exit_slot) : '0;
    assign grant_mask = granting ? (NUM_SLOTS'(1) << cand_slot) : '0;
    assign occ_next   = (occupied & ~exit_mask) | grant_mask;

    always_comb begin
        free_next = (SLOT_W + 1)'(NUM_SLOTS);
        for (int i = 0; i < NUM_SLOTS; i++) free_next = free_next - (SLOT_W + 1)'(occ_next[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupied   <= '0;
            free_count <= (SLOT_W + 1)'(NUM_SLOTS);
            lot_full   <= 1'b0;
            exit_err   <= 1'b0;
            g0_grant   <= 1'b0;
            g1_grant   <= 1'b0;
            deny       <= 1'b0;
            deny_code  <= '0;
            resp_gate  <= 1'b0;
            grant_slot <= '0;
            rr_last    <= 1'b1;
            sel_gate   <= 1'b0;
            sel_charge <= 1'b0;
            cand_ok    <= 1'b0;
            cand_slot  <= '0;
            cand_code  <= '0;
        end else begin
            occupied   <= occ_next;
            free_count <= free_next;
            lot_full   <= (free_next == '0);
            exit_err   <= exit_valid && !occupied[exit_slot];
            g0_grant   <= granting && !sel_gate;
            g1_grant   <= granting && sel_gate;
            deny       <= refusing;
            deny_code  <= refusing ? cand_code : '0;
            resp_gate  <= (state == RESP) ? sel_gate : 1'b0;
            grant_slot <= granting ? cand_slot : '0;
            if (state == RESP) rr_last <= sel_gate;
            if (state == IDLE) begin
                sel_gate   <= pick;
                sel_charge <= pick ? g1_charge : g0_charge;
            end
            if (state == SEARCH) begin
                cand_ok   <= s_ok;
                cand_slot <= s_slot;
                cand_code <= s_code;
            end
        end
    end
endmodule
